// File: rtl/gsu_pkg.sv
// Shared GSU definitions: cache geometry, fill engine states and the
// PC/CBR to cache byte address mapping also used by the core.
package gsu_pkg;

    localparam int GSU_LINE_LOG2 = 4;
    localparam int GSU_CACHE_AW  = 9;
    localparam int LINE_BYTES    = 1 << GSU_LINE_LOG2;
    localparam int CACHE_BYTES   = 1 << GSU_CACHE_AW;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_REQ,
        FILL_WAIT,
        FILL_DONE
    } fill_state_t;

    // Carries above the cache address width are discarded, so the cache wraps.
    function automatic logic [GSU_CACHE_AW-1:0] cache_addr(input logic [15:0] pc,
                                                          input logic [15:0] cbr);
        return GSU_CACHE_AW'(pc + cbr);
    endfunction

endpackage

// File: rtl/gsu_cache_fill_if.sv
// ROM read bus and cache RAM write/flag bus of the GSU cache fill engine.
// The master side is the fill engine; the slave side is ROM/cache glue.
interface gsu_cache_fill_if #(
    parameter int CACHE_AW  = gsu_pkg::GSU_CACHE_AW,
    parameter int LINE_LOG2 = gsu_pkg::GSU_LINE_LOG2
);
    logic                          rom_req;
    logic [23:0]                   rom_addr;
    logic                          rom_ack;
    logic [7:0]                    rom_data;
    logic                          cache_we;
    logic [CACHE_AW-1:0]           cache_waddr;
    logic [7:0]                    cache_wdata;
    logic                          flag_set;
    logic [CACHE_AW-LINE_LOG2-1:0] flag_idx;

    modport master (
        output rom_req, rom_addr, cache_we, cache_waddr, cache_wdata, flag_set, flag_idx,
        input  rom_ack, rom_data
    );

    modport slave (
        input  rom_req, rom_addr, cache_we, cache_waddr, cache_wdata, flag_set, flag_idx,
        output rom_ack, rom_data
    );
endinterface

// File: rtl/gsu_cache_fill.sv
// GSU instruction cache line fill engine: fetches one 16-byte line from ROM into cache RAM.
// Optional macro GSU_FILL_CRITICAL_FIRST_EN: start the fill at the missed byte, wrapping in the line.
//
// state     | meaning
// ----------+----------------------------------------------------------
// FILL_IDLE | waiting for miss_req; latches bank, line and cache index
// FILL_REQ  | waiting for ron before issuing the next ROM read
// FILL_WAIT | rom_req held until rom_ack or wait timer expiry
// FILL_DONE | last byte being written; flag_set pulses unless flushed
module gsu_cache_fill
    import gsu_pkg::*;
#(
    parameter int LINE_LOG2 = GSU_LINE_LOG2,
    parameter int CACHE_AW  = GSU_CACHE_AW,
    parameter int TIMEOUT   = 255
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              miss_req,
    input  logic [7:0]        miss_pbr,
    input  logic [15:0]       miss_pc,
    input  logic [15:0]       cbr,
    input  logic              flush,
    input  logic              ron,
    output logic              busy,
    output logic              fill_err,
    gsu_cache_fill_if.master  fill_bus
);

    localparam int IDX_W = CACHE_AW - LINE_LOG2;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    fill_state_t          state_q, state_d;
    logic [7:0]           pbr_q, pbr_d;
    logic [15-LINE_LOG2:0] lb_hi_q, lb_hi_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LINE_LOG2-1:0] off_q, off_d;
    logic [LINE_LOG2-1:0] left_q, left_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 req_q, req_d;
    logic [23:0]          addr_q, addr_d;
    logic                 we_q, we_d;
    logic [CACHE_AW-1:0]  waddr_q, waddr_d;
    logic [7:0]           wdata_q, wdata_d;

    logic [15:0]          miss_lb;
    logic [CACHE_AW-1:0]  miss_caddr;
    logic [LINE_LOG2-1:0] start_off;

    assign miss_lb    = miss_pc & ~16'(LINE_BYTES - 1);
    assign miss_caddr = cache_addr(miss_lb, cbr);

`ifdef GSU_FILL_CRITICAL_FIRST_EN
    assign start_off = miss_pc[LINE_LOG2-1:0];
`else
    assign start_off = '0;
`endif

    always_comb begin
        state_d = state_q;
        pbr_d   = pbr_q;
        lb_hi_d = lb_hi_q;
        idx_d   = idx_q;
        off_d   = off_q;
        left_d  = left_q;
        tmr_d   = tmr_q;
        busy_d  = busy_q;
        err_d   = err_q;
        req_d   = req_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        // Flush beats everything, including a same-cycle rom_ack.
        if (flush) begin
            state_d = FILL_IDLE;
            req_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                FILL_IDLE: begin
                    if (miss_req) begin
                        pbr_d   = miss_pbr;
                        lb_hi_d = miss_pc[15:LINE_LOG2];
                        idx_d   = miss_caddr[CACHE_AW-1:LINE_LOG2];
                        off_d   = start_off;
                        left_d  = '1;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                        state_d = FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (ron) begin
                        req_d   = 1'b1;
                        addr_d  = {pbr_q, lb_hi_q, off_q};
                        tmr_d   = TMR_W'(TIMEOUT);
                        state_d = FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (fill_bus.rom_ack) begin
                        req_d   = 1'b0;
                        we_d    = 1'b1;
                        waddr_d = {idx_q, off_q};
                        wdata_d = fill_bus.rom_data;
                        off_d   = off_q + 1'b1;
                        left_d  = left_q - 1'b1;
                        state_d = (left_q == '0) ? FILL_DONE : FILL_REQ;
                    end else if (tmr_q == '0) begin
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = FILL_IDLE;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                FILL_DONE: begin
                    busy_d  = 1'b0;
                    state_d = FILL_IDLE;
                end
                default: state_d = FILL_IDLE;
            endcase
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q <= FILL_IDLE;
            pbr_q   <= '0;
            lb_hi_q <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            left_q  <= '0;
            tmr_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            pbr_q   <= pbr_d;
            lb_hi_q <= lb_hi_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            left_q  <= left_d;
            tmr_q   <= tmr_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy                 = busy_q;
    assign fill_err             = err_q;
    assign fill_bus.rom_req     = req_q;
    assign fill_bus.rom_addr    = addr_q;
    assign fill_bus.cache_we    = we_q;
    assign fill_bus.cache_waddr = waddr_q;
    assign fill_bus.cache_wdata = wdata_q;
    assign fill_bus.flag_set    = (state_q == FILL_DONE) && !flush;
    assign fill_bus.flag_idx    = idx_q;

endmodule
